spi_flash_mapped: RTL and testbench

Memory-mapped, read-only window onto the SPI flash, on the SoC memory bus beside RAM and the IO page.
- The SoC address decoder drives sel for the flash page; the block receives the word address.
- The block runs a hardware SPI READ (0x03) transaction per word and holds the processor with rbusy until the word is available.
- Replaces software bit-banged flash reads. Code and data can then be executed or fetched directly from flash.

---
 rtl/spi_flash_mapped_pkg.sv | 19 +
 rtl/spi_flash_shifter.sv | 76 +++++++
 rtl/spi_flash_mapped.sv | 116 +++++++++++
 tb/tb_spi_flash_mapped.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_mapped_pkg.sv
// Shared constants, state encoding and helpers for the memory-mapped SPI flash window.
package spi_flash_mapped_pkg;

  localparam logic [7:0]  SPI_CMD_READ       = 8'h03;
  localparam int unsigned SPI_XFER_BITS      = 64;
  localparam logic [23:0] DEFAULT_FLASH_BASE = 24'h100000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Flash delivers bytes first-to-last into the shift register MSB side; the bus is little-endian.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_flash_shifter.sv
// SPI mode-0 bit engine: clock divider, bit counter, 32-bit TX phase then 32-bit RX phase.
module spi_flash_shifter
  import spi_flash_mapped_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] tx_word,
  output logic        done,
  output logic [31:0] rx_word,
  output logic        CLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] BIT_LAST = 6'(SPI_XFER_BITS - 1);

  logic        active;
  logic        clk_q;
  logic        mosi_q;
  logic [7:0]  div_q;
  logic [5:0]  bit_q;
  logic [31:0] tx_q;
  logic [31:0] rx_q;
  logic        div_end;

  assign div_end = (div_q == DIV_LAST);
  assign done    = active && clk_q && div_end && (bit_q == BIT_LAST);
  assign rx_word = rx_q;
  assign CLK     = clk_q;
  assign MOSI    = mosi_q;

  // MISO is captured on the edge that raises CLK, so the last bit is in rx_q before done fires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active <= 1'b0;
      clk_q  <= 1'b0;
      mosi_q <= 1'b0;
      div_q  <= '0;
      bit_q  <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
    end else if (start) begin
      active <= 1'b1;
      clk_q  <= 1'b0;
      div_q  <= '0;
      bit_q  <= '0;
      mosi_q <= tx_word[31];
      tx_q   <= {tx_word[30:0], 1'b0};
    end else if (active) begin
      if (!div_end) begin
        div_q <= div_q + 8'd1;
      end else begin
        div_q <= '0;
        if (!clk_q) begin
          clk_q <= 1'b1;
          if (bit_q >= 6'd32) rx_q <= {rx_q[30:0], MISO};
        end else begin
          clk_q <= 1'b0;
          if (bit_q == BIT_LAST) begin
            active <= 1'b0;
            mosi_q <= 1'b0;
          end else begin
            bit_q  <= bit_q + 6'd1;
            mosi_q <= (bit_q < 6'd31) ? tx_q[31] : 1'b0;
            tx_q   <= {tx_q[30:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/spi_flash_mapped.sv
// Read-only memory-mapped SPI flash window: one READ (0x03) transaction per bus word.
// Optional one-entry read cache enabled by defining SPI_FLASH_CACHE_EN.
module spi_flash_mapped
  import spi_flash_mapped_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 1,
  parameter logic [23:0] FLASH_BASE = DEFAULT_FLASH_BASE,
  parameter int unsigned ADDR_BITS  = 20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rstrb,
  input  logic                 sel,
  input  logic [ADDR_BITS-1:0] word_address,
  output logic [31:0]          rdata,
  output logic                 rbusy,
  output logic                 CLK,
  output logic                 CS_N,
  output logic                 MOSI,
  input  logic                 MISO
);

  state_t      state;
  logic        cs_n_q;
  logic [31:0] data_q;
  logic [23:0] byte_addr;
  logic        accept;
  logic        hit;
  logic        start;
  logic        done;
  logic [31:0] rx_word;
  logic [31:0] hit_data;

  assign byte_addr = FLASH_BASE + 24'({word_address, 2'b00});
  assign accept    = (state == ST_IDLE) && rstrb && sel;
  assign start     = accept && !hit;
  assign rbusy     = start || (state == ST_SHIFT);
  assign rdata     = (hit ? hit_data : data_q) & {32{sel}};
  assign CS_N      = cs_n_q;

`ifdef SPI_FLASH_CACHE_EN
  logic        cache_valid;
  logic [23:0] cache_addr;
  logic [23:0] fill_addr;
  logic [31:0] cache_data;

  assign hit      = accept && cache_valid && (cache_addr == byte_addr);
  assign hit_data = cache_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cache_valid <= 1'b0;
      cache_addr  <= '0;
      fill_addr   <= '0;
      cache_data  <= '0;
    end else begin
      if (start) fill_addr <= byte_addr;
      if (state == ST_SHIFT && done) begin
        cache_valid <= 1'b1;
        cache_addr  <= fill_addr;
        cache_data  <= byte_swap(rx_word);
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  // data_q is loaded on the SHIFT->DONE edge so rdata is valid in the cycle rbusy falls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cs_n_q <= 1'b1;
      data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_SHIFT;
            cs_n_q <= 1'b0;
          end else if (hit) begin
            data_q <= hit_data;
          end
        end
        ST_SHIFT: begin
          if (done) begin
            state  <= ST_DONE;
            cs_n_q <= 1'b1;
            data_q <= byte_swap(rx_word);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          state  <= ST_IDLE;
          cs_n_q <= 1'b1;
        end
      endcase
    end
  end

  spi_flash_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .tx_word ({SPI_CMD_READ, byte_addr}),
    .done    (done),
    .rx_word (rx_word),
    .CLK     (CLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

endmodule

// File: tb/tb_spi_flash_mapped.sv
// Directed bench for spi_flash_mapped: a CLK_DIV=1 instance and a CLK_DIV=3 instance share a flash model.
module tb_spi_flash_mapped;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rstrb;
  logic        sel1, sel3;
  logic [19:0] word_address;
  logic        miso;

  logic [31:0] rdata1, rdata3;
  logic        rbusy1, rbusy3;
  logic        sclk1, sclk3, cs_n1, cs_n3, mosi1, mosi3;

  logic        which;
  logic        m_rbusy, spi_clk, spi_cs_n, spi_mosi;
  logic [31:0] m_rdata;

  int          vectors = 0;
  int          miscompares = 0;

  logic [31:0] flash_word;
  logic [31:0] cmd;
  int          rises = 0;
  int          total_rises = 0;
  int          cs_falls = 0;
  int          last_falls = 0;
  time         t_r0, t_r1;

  always #5 clk = ~clk;

  spi_flash_mapped #(
    .CLK_DIV(1), .FLASH_BASE(24'h100000), .ADDR_BITS(20)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rstrb(rstrb), .sel(sel1),
    .word_address(word_address), .rdata(rdata1), .rbusy(rbusy1),
    .CLK(sclk1), .CS_N(cs_n1), .MOSI(mosi1), .MISO(miso)
  );

  // Base near the top of the 24-bit space so the address sum wraps.
  spi_flash_mapped #(
    .CLK_DIV(3), .FLASH_BASE(24'hD00000), .ADDR_BITS(20)
  ) dut3 (
    .clk(clk), .reset_n(reset_n), .rstrb(rstrb), .sel(sel3),
    .word_address(word_address), .rdata(rdata3), .rbusy(rbusy3),
    .CLK(sclk3), .CS_N(cs_n3), .MOSI(mosi3), .MISO(miso)
  );

  assign m_rbusy  = which ? rbusy3 : rbusy1;
  assign m_rdata  = which ? rdata3 : rdata1;
  assign spi_clk  = which ? sclk3  : sclk1;
  assign spi_cs_n = which ? cs_n3  : cs_n1;
  assign spi_mosi = which ? mosi3  : mosi1;

  always @(negedge spi_cs_n) cs_falls++;

  always @(posedge spi_clk) begin
    if (cs_falls != last_falls) begin
      rises = 0;
      last_falls = cs_falls;
    end
    if (!spi_cs_n) begin
      if (rises < 32) cmd = {cmd[30:0], spi_mosi};
      if (rises == 0) t_r0 = $time;
      if (rises == 1) t_r1 = $time;
      rises++;
      total_rises++;
    end
  end

  always @(negedge spi_clk) begin
    if (!spi_cs_n && rises >= 32 && rises < 64) miso = flash_word[63 - rises];
  end

  task automatic do_read(input logic [19:0] wa, input int repulse,
                         output logic busy0, output logic [31:0] data0,
                         output int cyc, output logic [31:0] data);
    @(negedge clk);
    word_address = wa;
    if (which) sel3 = 1'b1; else sel1 = 1'b1;
    rstrb = 1'b1;
    #1;
    busy0 = m_rbusy;
    data0 = m_rdata;
    @(negedge clk);
    rstrb = 1'b0;
    cyc = 1;
    while (m_rbusy && cyc < 2000) begin
      rstrb = (cyc == repulse);
      cyc++;
      @(negedge clk);
    end
    rstrb = 1'b0;
    data = m_rdata;
  endtask

  task automatic test_reset();
    logic b0; logic [31:0] d0, d; int cyc;
    reset_n = 1'b0; rstrb = 1'b0; sel1 = 1'b1; sel3 = 1'b0; which = 1'b0;
    word_address = '0; miso = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    vectors++; if (cs_n1 !== 1'b1) begin miscompares++; $display("FAIL reset_cs_n: got %b want 1", cs_n1); end
    vectors++; if (sclk1 !== 1'b0) begin miscompares++; $display("FAIL reset_clk: got %b want 0", sclk1); end
    vectors++; if (rbusy1 !== 1'b0) begin miscompares++; $display("FAIL reset_rbusy: got %b want 0", rbusy1); end
    vectors++; if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 00000000", rdata1); end
    flash_word = 32'hA5A55A5A;
    do_read(20'h00002, 0, b0, d0, cyc, d);
    vectors++; if (d !== 32'h5A5AA5A5) begin miscompares++; $display("FAIL reset_preload: got %h want 5a5aa5a5", d); end
    repeat (3) @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    vectors++; if (cs_n1 !== 1'b1) begin miscompares++; $display("FAIL idle_reset_cs_n: got %b want 1", cs_n1); end
    vectors++; if (sclk1 !== 1'b0) begin miscompares++; $display("FAIL idle_reset_clk: got %b want 0", sclk1); end
    vectors++; if (mosi1 !== 1'b0) begin miscompares++; $display("FAIL idle_reset_mosi: got %b want 0", mosi1); end
    vectors++; if (rbusy1 !== 1'b0) begin miscompares++; $display("FAIL idle_reset_rbusy: got %b want 0", rbusy1); end
    vectors++; if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL idle_reset_rdata: got %h want 00000000", rdata1); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic b0; logic [31:0] d0, d; int cyc, f0, r0;
    flash_word = 32'h11223344;
    f0 = cs_falls; r0 = total_rises;
    do_read(20'h00001, 0, b0, d0, cyc, d);
    vectors++; if (b0 !== 1'b1) begin miscompares++; $display("FAIL basic_rbusy_cycle0: got %b want 1", b0); end
    vectors++; if (cyc !== 129) begin miscompares++; $display("FAIL basic_busy_cycles: got %0d want 129", cyc); end
    vectors++; if (d !== 32'h44332211) begin miscompares++; $display("FAIL basic_rdata: got %h want 44332211", d); end
    vectors++; if (cmd !== 32'h03100004) begin miscompares++; $display("FAIL basic_mosi: got %h want 03100004", cmd); end
    vectors++; if (cs_falls - f0 !== 1) begin miscompares++; $display("FAIL basic_cs_falls: got %0d want 1", cs_falls - f0); end
    vectors++; if (total_rises - r0 !== 64) begin miscompares++; $display("FAIL basic_clk_rises: got %0d want 64", total_rises - r0); end
    vectors++; if (cs_n1 !== 1'b1) begin miscompares++; $display("FAIL basic_done_cs_n: got %b want 1", cs_n1); end
    @(negedge clk);
    sel1 = 1'b0; #1;
    vectors++; if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL basic_sel_low: got %h want 00000000", rdata1); end
    sel1 = 1'b1; #1;
    vectors++; if (rdata1 !== 32'h44332211) begin miscompares++; $display("FAIL basic_hold: got %h want 44332211", rdata1); end
  endtask

  task automatic test_back_to_back_strobe();
    logic b0; logic [31:0] d0, d; int cyc, f0, r0;
    flash_word = 32'h55AA00FF;
    f0 = cs_falls; r0 = total_rises;
    do_read(20'h00003, 40, b0, d0, cyc, d);
    repeat (5) @(negedge clk);
    vectors++; if (cyc !== 129) begin miscompares++; $display("FAIL ignore_busy_cycles: got %0d want 129", cyc); end
    vectors++; if (cs_falls - f0 !== 1) begin miscompares++; $display("FAIL ignore_cs_falls: got %0d want 1", cs_falls - f0); end
    vectors++; if (total_rises - r0 !== 64) begin miscompares++; $display("FAIL ignore_clk_rises: got %0d want 64", total_rises - r0); end
    vectors++; if (d !== 32'hFF00AA55) begin miscompares++; $display("FAIL ignore_rdata: got %h want ff00aa55", d); end
    vectors++; if (cmd !== 32'h0310000C) begin miscompares++; $display("FAIL ignore_mosi: got %h want 0310000c", cmd); end
  endtask

  task automatic test_abort();
    logic b0; logic [31:0] d0, d; int cyc;
    flash_word = 32'h0BADF00D;
    @(negedge clk);
    word_address = 20'h00007; sel1 = 1'b1; rstrb = 1'b1;
    @(negedge clk);
    rstrb = 1'b0;
    repeat (40) @(negedge clk);
    vectors++; if (cs_n1 !== 1'b0) begin miscompares++; $display("FAIL abort_active_cs_n: got %b want 0", cs_n1); end
    #2 reset_n = 1'b0;
    #1;
    vectors++; if (cs_n1 !== 1'b1) begin miscompares++; $display("FAIL abort_cs_n: got %b want 1", cs_n1); end
    vectors++; if (sclk1 !== 1'b0) begin miscompares++; $display("FAIL abort_clk: got %b want 0", sclk1); end
    vectors++; if (rbusy1 !== 1'b0) begin miscompares++; $display("FAIL abort_rbusy: got %b want 0", rbusy1); end
    @(negedge clk);
    reset_n = 1'b1;
    flash_word = 32'h76543210;
    do_read(20'h00000, 0, b0, d0, cyc, d);
    vectors++; if (cmd !== 32'h03100000) begin miscompares++; $display("FAIL abort_next_mosi: got %h want 03100000", cmd); end
    vectors++; if (d !== 32'h10325476) begin miscompares++; $display("FAIL abort_next_rdata: got %h want 10325476", d); end
    vectors++; if (cyc !== 129) begin miscompares++; $display("FAIL abort_next_busy: got %0d want 129", cyc); end
  endtask

  task automatic test_clk_div3();
    logic b0; logic [31:0] d0, d; int cyc, r0;
    sel1 = 1'b0; which = 1'b1;
    flash_word = 32'hDEADBEEF;
    r0 = total_rises;
    do_read(20'hFFFFF, 0, b0, d0, cyc, d);
    vectors++; if (cyc !== 385) begin miscompares++; $display("FAIL div3_busy_cycles: got %0d want 385", cyc); end
    vectors++; if (cmd !== 32'h030FFFFC) begin miscompares++; $display("FAIL div3_wrap_mosi: got %h want 030ffffc", cmd); end
    vectors++; if (d !== 32'hEFBEADDE) begin miscompares++; $display("FAIL div3_rdata: got %h want efbeadde", d); end
    vectors++; if (t_r1 - t_r0 !== 60) begin miscompares++; $display("FAIL div3_period: got %0t want 60", t_r1 - t_r0); end
    vectors++; if (total_rises - r0 !== 64) begin miscompares++; $display("FAIL div3_clk_rises: got %0d want 64", total_rises - r0); end
    @(negedge clk);
    sel3 = 1'b0; which = 1'b0; sel1 = 1'b1;
  endtask

  task automatic test_cache();
    logic b0; logic [31:0] d0, d; int cyc, f0;
    flash_word = 32'hCAFEF00D;
    do_read(20'h00010, 0, b0, d0, cyc, d);
    vectors++; if (d !== 32'h0DF0FECA) begin miscompares++; $display("FAIL cache_first_rdata: got %h want 0df0feca", d); end
    flash_word = 32'hFFFFFFFF;
    f0 = cs_falls;
    do_read(20'h00010, 0, b0, d0, cyc, d);
    repeat (3) @(negedge clk);
`ifdef SPI_FLASH_CACHE_EN
    vectors++; if (b0 !== 1'b0) begin miscompares++; $display("FAIL cache_hit_rbusy: got %b want 0", b0); end
    vectors++; if (d0 !== 32'h0DF0FECA) begin miscompares++; $display("FAIL cache_hit_same_cycle: got %h want 0df0feca", d0); end
    vectors++; if (cs_falls - f0 !== 0) begin miscompares++; $display("FAIL cache_hit_cs_falls: got %0d want 0", cs_falls - f0); end
    vectors++; if (d !== 32'h0DF0FECA) begin miscompares++; $display("FAIL cache_hit_hold: got %h want 0df0feca", d); end
`else
    vectors++; if (b0 !== 1'b1) begin miscompares++; $display("FAIL repeat_rbusy: got %b want 1", b0); end
    vectors++; if (cs_falls - f0 !== 1) begin miscompares++; $display("FAIL repeat_cs_falls: got %0d want 1", cs_falls - f0); end
    vectors++; if (d !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL repeat_rdata: got %h want ffffffff", d); end
`endif
    flash_word = 32'h01020304;
    do_read(20'h00011, 0, b0, d0, cyc, d);
    vectors++; if (cyc !== 129) begin miscompares++; $display("FAIL cache_miss_busy: got %0d want 129", cyc); end
    vectors++; if (cmd !== 32'h03100044) begin miscompares++; $display("FAIL cache_miss_mosi: got %h want 03100044", cmd); end
    vectors++; if (d !== 32'h04030201) begin miscompares++; $display("FAIL cache_miss_rdata: got %h want 04030201", d); end
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    flash_word = 32'hCAFEF00D;
    f0 = cs_falls;
    do_read(20'h00010, 0, b0, d0, cyc, d);
    vectors++; if (b0 !== 1'b1) begin miscompares++; $display("FAIL cache_after_reset_rbusy: got %b want 1", b0); end
    vectors++; if (cyc !== 129) begin miscompares++; $display("FAIL cache_after_reset_busy: got %0d want 129", cyc); end
    vectors++; if (cs_falls - f0 !== 1) begin miscompares++; $display("FAIL cache_after_reset_cs: got %0d want 1", cs_falls - f0); end
    vectors++; if (d !== 32'h0DF0FECA) begin miscompares++; $display("FAIL cache_after_reset_rdata: got %h want 0df0feca", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back_strobe();
    test_abort();
    test_clk_div3();
    test_cache();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
